// File: rtl/countdown_pkg.sv
// Shared definitions for the loadable down-counter.
// Mode encoding, FSM state type and default width.
package countdown_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic MODE_STEP      = 1'b0;
  localparam logic MODE_OVERWRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/countdown_counter.sv
// Loadable saturating down-counter with one-cycle expiry pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic reload on expiry.
module countdown_counter
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             en,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             expired,
  output logic             busy
);

  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expired_q, expired_d;
  logic             busy_q, busy_d;
  logic [WIDTH:0]   diff;
  logic             hits_zero;

  // Borrow or exact zero both mean the step lands on zero.
  assign diff      = {1'b0, count_q} - STEP_X;
  assign hits_zero = diff[WIDTH] || (diff[WIDTH-1:0] == '0);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;
    if (mode == MODE_OVERWRITE) begin
      count_d  = write_data;
      reload_d = write_data;
      state_d  = (write_data != '0) ? RUN : IDLE;
    end else if (state_q == RUN) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      if (count_q == '0 && reload_q != '0) begin
        count_d = reload_q;
      end else if (en) begin
        if (hits_zero) begin
          count_d   = '0;
          expired_d = 1'b1;
          state_d   = (reload_q != '0) ? RUN : DONE;
        end else begin
          count_d = diff[WIDTH-1:0];
        end
      end
`else
      if (en) begin
        if (hits_zero) begin
          count_d   = '0;
          expired_d = 1'b1;
          state_d   = DONE;
        end else begin
          count_d = diff[WIDTH-1:0];
        end
      end
`endif
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
      busy_q    <= busy_d;
    end
  end

  assign count   = count_q;
  assign zero    = (count_q == '0);
  assign expired = expired_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_countdown_counter.sv
// Bench for countdown_counter: STEP=1 and STEP=4 instances,
// per-cycle model compare plus directed literal checks.
module tb_countdown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode = 1'b0;
  logic       en = 1'b0;
  logic [7:0] wd = 8'h00;

  logic [7:0] c1, c4;
  logic       z1, z4, e1, e4, b1, b4;

  int nchk = 0;
  int nerr = 0;

  countdown_counter #(.WIDTH(8), .STEP(1)) u1 (
    .clk(clk), .rst(rst), .mode(mode), .en(en),
    .write_data(wd), .count(c1), .zero(z1),
    .expired(e1), .busy(b1)
  );

  countdown_counter #(.WIDTH(8), .STEP(4)) u4 (
    .clk(clk), .rst(rst), .mode(mode), .en(en),
    .write_data(wd), .count(c4), .zero(z4),
    .expired(e4), .busy(b4)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: remaining time, running flag, reload value
  int m_cnt[2];
  int m_rl[2];
  bit m_run[2];
  bit m_exp[2];
  int steps[2] = '{1, 4};
  bit p_exp[2];
  bit auto_rl;

  initial begin
    auto_rl = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    auto_rl = 1'b1;
`endif
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] <= 0;
        m_rl[i]  <= 0;
        m_run[i] <= 1'b0;
        m_exp[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int nc;
        nc = m_cnt[i] - steps[i];
        if (nc < 0) nc = 0;
        m_exp[i] <= 1'b0;
        if (mode) begin
          m_cnt[i] <= int'(wd);
          m_rl[i]  <= int'(wd);
          m_run[i] <= (wd != 0);
        end else if (m_run[i] && auto_rl
                     && m_cnt[i] == 0 && m_rl[i] != 0) begin
          m_cnt[i] <= m_rl[i];
        end else if (m_run[i] && en) begin
          m_cnt[i] <= nc;
          if (nc == 0) begin
            m_exp[i] <= 1'b1;
            m_run[i] <= auto_rl && (m_rl[i] != 0);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m1_count", int'(c1), m_cnt[0]);
    chk("m1_zero", int'(z1), int'(m_cnt[0] == 0));
    chk("m1_exp", int'(e1), int'(m_exp[0]));
    chk("m1_busy", int'(b1), int'(m_run[0]));
    chk("m4_count", int'(c4), m_cnt[1]);
    chk("m4_zero", int'(z4), int'(m_cnt[1] == 0));
    chk("m4_exp", int'(e4), int'(m_exp[1]));
    chk("m4_busy", int'(b4), int'(m_run[1]));
    if (!auto_rl) begin
      chk("m1_exp_twice", int'(e1 && p_exp[0]), 0);
      chk("m4_exp_twice", int'(e4 && p_exp[1]), 0);
    end
    p_exp[0] = e1;
    p_exp[1] = e4;
  end

  task automatic cyc(logic m, logic e, logic [7:0] d);
    mode = m;
    en   = e;
    wd   = d;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_count", int'(c1), 0);
    chk("rst_zero", int'(z1), 1);
    chk("rst_busy", int'(b1), 0);
    chk("rst_exp", int'(e1), 0);
    @(negedge clk);
    #1;
    rst = 1'b1;

    // basic countdown from 3
    cyc(1, 0, 8'h03);
    chk("ld3_count", int'(c1), 3);
    chk("ld3_busy", int'(b1), 1);
    cyc(0, 1, 0);
    chk("bc_2", int'(c1), 2);
    cyc(0, 1, 0);
    chk("bc_1", int'(c1), 1);
    chk("bc_1_exp", int'(e1), 0);
    cyc(0, 1, 0);
    chk("bc_0", int'(c1), 0);
    chk("bc_0_exp", int'(e1), 1);
    chk("bc_0_zero", int'(z1), 1);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    cyc(0, 1, 0);
    chk("bc_hold0", int'(c1), 0);
    chk("bc_hold_exp", int'(e1), 0);
    chk("bc_done_busy", int'(b1), 0);
`endif

    // saturation with STEP=4
    cyc(1, 0, 8'h0A);
    cyc(0, 1, 0);
    chk("s4_6", int'(c4), 6);
    chk("s1_9", int'(c1), 9);
    cyc(0, 1, 0);
    chk("s4_2", int'(c4), 2);
    cyc(0, 1, 0);
    chk("s4_0", int'(c4), 0);
    chk("s4_exp", int'(e4), 1);
    chk("s1_7", int'(c1), 7);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    cyc(0, 1, 0);
    chk("s4_nowrap", int'(c4), 0);
    chk("s4_exp_off", int'(e4), 0);
`endif

    // overwrite wins over an expiring step
    cyc(1, 0, 8'h01);
    cyc(1, 1, 8'hAA);
    chk("ow_count", int'(c1), 170);
    chk("ow_exp", int'(e1), 0);
    chk("ow_busy", int'(b1), 1);

    // enable gating
    cyc(1, 0, 8'h05);
    cyc(0, 1, 0);
    chk("eg_4a", int'(c1), 4);
    cyc(0, 0, 0);
    chk("eg_4b", int'(c1), 4);
    cyc(0, 1, 0);
    chk("eg_3a", int'(c1), 3);
    cyc(0, 0, 0);
    chk("eg_3b", int'(c1), 3);
    cyc(0, 1, 0);
    chk("eg_2", int'(c1), 2);

    // load zero: idle, no pulse
    cyc(1, 0, 8'h00);
    chk("l0_count", int'(c1), 0);
    chk("l0_busy", int'(b1), 0);
    cyc(0, 1, 0);
    chk("l0_exp", int'(e1), 0);

    // mid-run asynchronous reset
    cyc(1, 0, 8'h10);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("mr_0d", int'(c1), 13);
    rst = 1'b0;
    #1;
    chk("mr_count", int'(c1), 0);
    chk("mr_zero", int'(z1), 1);
    chk("mr_busy", int'(b1), 0);
    rst = 1'b1;
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("mr_after", int'(c1), 0);
    chk("mr_after_exp", int'(e1), 0);

    // full range: 255 steps to expiry
    cyc(1, 0, 8'hFF);
    for (int i = 0; i < 254; i++) cyc(0, 1, 0);
    chk("ff_1", int'(c1), 1);
    chk("ff_1_exp", int'(e1), 0);
    cyc(0, 1, 0);
    chk("ff_0", int'(c1), 0);
    chk("ff_0_exp", int'(e1), 1);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // periodic reload from 2
    cyc(1, 0, 8'h02);
    cyc(0, 1, 0);
    chk("ar_1", int'(c1), 1);
    cyc(0, 1, 0);
    chk("ar_0", int'(c1), 0);
    chk("ar_exp", int'(e1), 1);
    cyc(0, 1, 0);
    chk("ar_2", int'(c1), 2);
    chk("ar_busy", int'(b1), 1);
`endif

    cyc(0, 0, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
